// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage controller: owns the PC and IF/ID register, obeys stall/flush, and drives a
// single-outstanding imem handshake. One-cycle fetch latency; a stalled response waits in a skid register.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        req_q, req_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  assign target_aligned = branch_target_i & ~32'h0000_0003;
  assign pc_plus4       = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    stall_cnt_d   = stall_cnt_q;

    if (flush_i) begin
      // Redirect wins over everything; any same-cycle response is dropped.
      pc_d          = target_aligned;
      if_id_pc_d    = 32'h0;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
      skid_d        = 32'h0;
      state_d       = FETCH;
    end else begin
      unique case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (imem_valid_i) begin
            if (stall_i) begin
              skid_d  = imem_rdata_i;
              state_d = HOLD;
            end else begin
              if_id_pc_d    = pc_q;
              if_id_inst_d  = imem_rdata_i;
              if_id_valid_d = 1'b1;
              pc_d          = pc_plus4;
            end
          end else if (!stall_i) begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          // Release presents the captured word; no refetch of the same PC.
          if (!stall_i) begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = skid_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
            state_d       = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end

    if (stall_i && if_id_valid_q && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      skid_q        <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      req_q         <= 1'b0;
      stall_cnt_q   <= 16'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_q        <= skid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      req_q         <= req_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign if_id_valid_o = if_id_valid_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
